matmul_result_reader: RTL and testbench



---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matmul_rd_index_ctr.sv | 39 +++
 rtl/matmul_result_reader.sv | 176 +++++++++++++++++
 tb/tb_matmul_result_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared matmul definitions: default widths, the result-reader state encoding and
// the element bit-offset helper that the array, reader and writer blocks all use.
package matmul_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int BUS_WIDTH_DEF  = 32;
    localparam int ELEM_WIDTH_DEF = 2 * DATA_WIDTH_DEF;
    localparam int MAX_DIM_DEF    = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLAGS  = 2'd2,
        ST_DONE   = 2'd3
    } rd_state_e;

    // Element (r,c) of the flat C matrix starts at this bit offset.
    function automatic int unsigned elem_offset(input int unsigned r,
                                                input int unsigned c,
                                                input int unsigned max_dim,
                                                input int unsigned elem_w);
        return (r * max_dim + c) * elem_w;
    endfunction

endpackage

// File: rtl/matmul_rd_index_ctr.sv
// Row/column walker for the result reader: row-major order, column wraps at m,
// last_o marks element (n-1,m-1). The *_nxt_o outputs preview the post-advance position.
module matmul_rd_index_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic [1:0] n_dim_i,
    input  logic [1:0] m_dim_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic [1:0] row_nxt_o,
    output logic [1:0] col_nxt_o,
    output logic       last_o
);

    logic col_wrap;

    always_comb begin
        col_wrap  = (col_o == m_dim_i - 2'd1);
        row_nxt_o = col_wrap ? row_o + 2'd1 : row_o;
        col_nxt_o = col_wrap ? 2'd0 : col_o + 2'd1;
        last_o    = col_wrap && (row_o == n_dim_i - 2'd1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_o <= 2'd0;
            col_o <= 2'd0;
        end else if (clear_i) begin
            row_o <= 2'd0;
            col_o <= 2'd0;
        end else if (advance_i) begin
            row_o <= row_nxt_o;
            col_o <= col_nxt_o;
        end
    end

endmodule

// File: rtl/matmul_result_reader.sv
// Snapshots the systolic array result and streams the valid N x M elements one per beat.
// Build option MATMUL_RD_FLAGS_BEAT_EN appends a beat carrying the masked overflow flags.
module matmul_result_reader
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int ADDR_WIDTH = 8,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int ELEM_W    = 2 * DATA_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [1:0]                          n_dim_i,
    input  logic [1:0]                          m_dim_i,
    input  logic [ADDR_WIDTH-1:0]               base_addr_i,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   c_matrix_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]          flags_i,
    output logic [BUS_WIDTH-1:0]                data_o,
    output logic [ADDR_WIDTH-1:0]               addr_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                ovf_o,
    output logic [1:0]                          state_o
);

    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = $clog2(NE);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] STREAM = ST_STREAM;
    localparam logic [1:0] DONE   = ST_DONE;
`ifdef MATMUL_RD_FLAGS_BEAT_EN
    localparam logic [1:0] FLAGS  = ST_FLAGS;
`endif

    logic [1:0]            state_q;
    logic [NE*ELEM_W-1:0]  c_q;
    logic [NE-1:0]         flags_q;
    logic [1:0]            n_q;
    logic [1:0]            m_q;
    logic [ADDR_WIDTH-1:0] base_q;

    logic [1:0]            row, col, row_nxt, col_nxt;
    logic                  last;
    logic [IW-1:0]         cur_idx, nxt_idx;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [ELEM_W-1:0]     elem_a [NE];
    logic                  accept;

    function automatic logic [BUS_WIDTH-1:0] sext(input logic [ELEM_W-1:0] e);
        return BUS_WIDTH'($signed(e));
    endfunction

    // Dimensions above MAX_DIM are clamped; zero is kept so it can skip straight to DONE.
    function automatic logic [1:0] clamp_dim(input logic [1:0] d);
        if (int'(d) > MAX_DIM) return 2'(MAX_DIM);
        return d;
    endfunction

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            assign elem_a[r*MAX_DIM+c] = c_q[elem_offset(r, c, MAX_DIM, ELEM_W) +: ELEM_W];
        end
    end

`ifdef MATMUL_RD_FLAGS_BEAT_EN
    logic [NE-1:0] valid_mask;
    for (genvar r = 0; r < MAX_DIM; r++) begin : g_mrow
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_mcol
            assign valid_mask[r*MAX_DIM+c] = (r < int'(n_q)) && (c < int'(m_q));
        end
    end
`endif

    // Handshake: a beat transfers on a rising edge where valid_o && ready_i. valid_o,
    // data_o and addr_o are registers that only change after a transfer (or at capture),
    // so they are stable while stalled and never depend combinationally on ready_i.
    assign accept   = (state_q == STREAM) && valid_o && ready_i;
    assign cur_idx  = IW'(int'(row) * MAX_DIM + int'(col));
    assign nxt_idx  = IW'(int'(row_nxt) * MAX_DIM + int'(col_nxt));
    assign nxt_addr = base_q + ADDR_WIDTH'(int'(row_nxt) * MAX_DIM + int'(col_nxt));
    assign state_o  = state_q;

    matmul_rd_index_ctr u_idx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   ((state_q == IDLE) && start_i),
        .advance_i (accept),
        .n_dim_i   (n_q),
        .m_dim_i   (m_q),
        .row_o     (row),
        .col_o     (col),
        .row_nxt_o (row_nxt),
        .col_nxt_o (col_nxt),
        .last_o    (last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            c_q     <= '0;
            flags_q <= '0;
            n_q     <= 2'd0;
            m_q     <= 2'd0;
            base_q  <= '0;
            data_o  <= '0;
            addr_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        c_q     <= c_matrix_i;
                        flags_q <= flags_i;
                        n_q     <= clamp_dim(n_dim_i);
                        m_q     <= clamp_dim(m_dim_i);
                        base_q  <= base_addr_i;
                        ovf_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        if (n_dim_i == 2'd0 || m_dim_i == 2'd0) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= STREAM;
                            valid_o <= 1'b1;
                            data_o  <= sext(c_matrix_i[ELEM_W-1:0]);
                            addr_o  <= base_addr_i;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        ovf_o <= ovf_o | flags_q[cur_idx];
                        if (last) begin
`ifdef MATMUL_RD_FLAGS_BEAT_EN
                            state_q <= FLAGS;
                            data_o  <= BUS_WIDTH'(flags_q & valid_mask);
                            addr_o  <= base_q + ADDR_WIDTH'(NE);
`else
                            state_q <= DONE;
                            valid_o <= 1'b0;
                            done_o  <= 1'b1;
`endif
                        end else begin
                            data_o <= sext(elem_a[nxt_idx]);
                            addr_o <= nxt_addr;
                        end
                    end
                end
`ifdef MATMUL_RD_FLAGS_BEAT_EN
                FLAGS: begin
                    if (valid_o && ready_i) begin
                        state_q <= DONE;
                        valid_o <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_reader.sv
// Directed bench for matmul_result_reader: table of captures with hand-computed beats,
// plus hand-written sequences for reset at power-up and reset mid-stream.
module tb_matmul_result_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [1:0]   n_dim;
    logic [1:0]   m_dim;
    logic [7:0]   base;
    logic [127:0] cmat;
    logic [3:0]   flags;
    logic [31:0]  data_o;
    logic [7:0]   addr_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;
    logic         ovf_o;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [1:0]        n;
        logic [1:0]        m;
        logic [7:0]        base;
        logic [127:0]      c;
        logic [3:0]        flags;
        bit                toggle;
        bit                repulse;
        int                nbeats;
        logic              ovf;
        logic [3:0][39:0]  beats;
        logic [39:0]       fbeat;
    } vec_t;

    vec_t vecs[7];

    matmul_result_reader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .n_dim_i     (n_dim),
        .m_dim_i     (m_dim),
        .base_addr_i (base),
        .c_matrix_i  (cmat),
        .flags_i     (flags),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 40'(valid_o), 40'd0);
        check({tag, "_busy"},  40'(busy_o),  40'd0);
        check({tag, "_done"},  40'(done_o),  40'd0);
        check({tag, "_ovf"},   40'(ovf_o),   40'd0);
        check({tag, "_data"},  40'(data_o),  40'd0);
        check({tag, "_addr"},  40'(addr_o),  40'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          cyc, acc, last_acc, exp_beats;
        bit          got_done, stalled;
        logic [7:0]  held_a;
        logic [31:0] held_d;
        logic [39:0] e;
        v = vecs[i];
        exp_q.delete();
        for (int k = 0; k < v.nbeats; k++) exp_q.push_back(v.beats[k]);
        exp_beats = v.nbeats;
`ifdef MATMUL_RD_FLAGS_BEAT_EN
        if (v.nbeats > 0) begin
            exp_q.push_back(v.fbeat);
            exp_beats++;
        end
`endif
        @(negedge clk);
        n_dim = v.n; m_dim = v.m; base = v.base; cmat = v.c; flags = v.flags;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; acc = 0; last_acc = -1; got_done = 0; stalled = 0;
        held_a = '0; held_d = '0;
        while (!got_done && cyc < 100) begin
            if (done_o) begin
                got_done = 1;
                check("done_timing", 40'(cyc), 40'(last_acc + 1));
                check("beat_count", 40'(acc), 40'(exp_beats));
                check("ovf_at_done", 40'(ovf_o), 40'(v.ovf));
                check("busy_in_done", 40'(busy_o), 40'd1);
                check("valid_in_done", 40'(valid_o), 40'd0);
            end else begin
                check("busy_stream", 40'(busy_o), 40'd1);
                if (stalled) begin
                    check("stall_addr", 40'(addr_o), 40'(held_a));
                    check("stall_data", 40'(data_o), 40'(held_d));
                end
                if (v.repulse && cyc == 1) begin
                    start = 1'b1;
                    cmat  = {4{32'hDEADBEEF}};
                    base  = 8'h99;
                end else begin
                    start = 1'b0;
                end
                ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
                if (valid_o && ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 40'({addr_o, data_o}), 40'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", 40'(addr_o), 40'(e[39:32]));
                        check("beat_data", 40'(data_o), 40'(e[31:0]));
                    end
                    acc++;
                    last_acc = cyc;
                    stalled = 0;
                end else if (valid_o) begin
                    stalled = 1;
                    held_a = addr_o;
                    held_d = data_o;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        if (!got_done) begin
            check("done_timeout", 40'd0, 40'd1);
        end else begin
            check("done_pulse_end", 40'(done_o), 40'd0);
            check("busy_after", 40'(busy_o), 40'd0);
            check("state_idle", 40'(state_o), 40'd0);
        end
        check("leftover_beats", 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        vecs[0] = '{n: 2'd2, m: 2'd2, base: 8'h10,
                    c: {32'h7FFFFFFF, 32'd3, 32'hFFFFFFFE, 32'd1},
                    flags: 4'b0000, toggle: 1'b0, repulse: 1'b0, nbeats: 4, ovf: 1'b0,
                    beats: {40'h13_7FFFFFFF, 40'h12_00000003, 40'h11_FFFFFFFE, 40'h10_00000001},
                    fbeat: 40'h14_00000000};
        vecs[1] = '{n: 2'd1, m: 2'd2, base: 8'h20,
                    c: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    flags: 4'b0010, toggle: 1'b0, repulse: 1'b0, nbeats: 2, ovf: 1'b1,
                    beats: {40'h0, 40'h0, 40'h21_22222222, 40'h20_11111111},
                    fbeat: 40'h24_00000002};
        vecs[2] = '{n: 2'd2, m: 2'd1, base: 8'h30,
                    c: {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0},
                    flags: 4'b0110, toggle: 1'b1, repulse: 1'b0, nbeats: 2, ovf: 1'b1,
                    beats: {40'h0, 40'h0, 40'h32_A2A2A2A2, 40'h30_A0A0A0A0},
                    fbeat: 40'h34_00000004};
        vecs[3] = '{n: 2'd3, m: 2'd3, base: 8'hFE,
                    c: {32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
                    flags: 4'b1000, toggle: 1'b0, repulse: 1'b0, nbeats: 4, ovf: 1'b1,
                    beats: {40'h01_12345678, 40'h00_FFFFFFFF, 40'hFF_00000000, 40'hFE_80000000},
                    fbeat: 40'h02_00000008};
        vecs[4] = '{n: 2'd0, m: 2'd2, base: 8'h60,
                    c: {4{32'h55555555}},
                    flags: 4'b1111, toggle: 1'b0, repulse: 1'b0, nbeats: 0, ovf: 1'b0,
                    beats: {40'h0, 40'h0, 40'h0, 40'h0},
                    fbeat: 40'h0};
        vecs[5] = '{n: 2'd2, m: 2'd2, base: 8'h40,
                    c: {32'hCAFEF00D, 32'h0000BEEF, 32'h00000042, 32'hFFFF0000},
                    flags: 4'b1001, toggle: 1'b0, repulse: 1'b1, nbeats: 4, ovf: 1'b1,
                    beats: {40'h43_CAFEF00D, 40'h42_0000BEEF, 40'h41_00000042, 40'h40_FFFF0000},
                    fbeat: 40'h44_00000009};
        vecs[6] = '{n: 2'd1, m: 2'd1, base: 8'h50,
                    c: {32'h99999999, 32'h88888888, 32'h77777777, 32'h0000ABCD},
                    flags: 4'b1110, toggle: 1'b0, repulse: 1'b0, nbeats: 1, ovf: 1'b0,
                    beats: {40'h0, 40'h0, 40'h0, 40'h50_0000ABCD},
                    fbeat: 40'h54_00000000};

        rst = 1'b1; start = 1'b0; ready = 1'b0;
        n_dim = 2'd0; m_dim = 2'd0; base = '0; cmat = '0; flags = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", 40'(state_o), 40'd0);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset after the first accepted beat: abort at once, no done pulse.
        @(negedge clk);
        n_dim = 2'd2; m_dim = 2'd2; base = 8'h10; cmat = vecs[0].c; flags = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; ready = 1'b1;
        check("mid_first_valid", 40'(valid_o), 40'd1);
        @(negedge clk);
        check("mid_ovf_set", 40'(ovf_o), 40'd1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("mid_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_done_after_rst", 40'(done_o), 40'd0);
        end
        rst = 1'b0;
        ready = 1'b0;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
